// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, entry type and helpers for the fetch stage
package fetch_pkg;

  // Canonical no-op (addi x0, x0, 0) presented when no instruction is ready
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  // Width of the stale-response counter; outstanding discards stay far below this
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are ignored
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch buffer with allocate, fill-oldest, pop and flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          fill,
  input  logic [31:0]   fill_data,
  input  logic          pop,
  output fetch_entry_t  head_entry,
  output logic [CW-1:0] count,
  output logic [CW-1:0] unfilled
);

  fetch_entry_t  entries [QDEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] fill_ptr;
  logic          head_ready;
  logic          do_alloc;
  logic          do_fill;
  logic          do_pop;

  // Qualify each operation so an out-of-protocol neighbour cannot corrupt pointers
  always_comb begin
    head_entry = entries[head_ptr];
    head_ready = (count != '0) && head_entry.filled;
    do_alloc   = alloc && !flush && (count != CW'(QDEPTH));
    do_fill    = fill && !flush && (unfilled != '0);
    do_pop     = pop && !flush && head_ready;
  end

  // Pointers and occupancy; responses return in order so fill_ptr walks behind tail_ptr
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      count    <= '0;
      unfilled <= '0;
    end else begin
      if (do_alloc) tail_ptr <= tail_ptr + 1'b1;
      if (do_fill)  fill_ptr <= fill_ptr + 1'b1;
      if (do_pop)   head_ptr <= head_ptr + 1'b1;
      count    <= count + CW'(do_alloc) - CW'(do_pop);
      unfilled <= unfilled + CW'(do_alloc) - CW'(do_fill);
    end
  end

  // Entry payload: allocation records the pc, a fill lands the word in the oldest unfilled slot
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      if (do_alloc) begin
        entries[tail_ptr].pc     <= alloc_pc;
        entries[tail_ptr].instr  <= '0;
        entries[tail_ptr].filled <= 1'b0;
      end
      if (do_fill) begin
        entries[fill_ptr].instr  <= fill_data;
        entries[fill_ptr].filled <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: pc, request gating, stale-response drop, redirect
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] NOP      = FETCH_NOP
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  output logic [31:0] PC_plus_4_out,
  output logic [31:0] Instruction_out
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]       pc;
  logic [DROP_W-1:0] drop_cnt;
  logic [DROP_W-1:0] outstanding;
  logic [DROP_W-1:0] drop_after_redirect;
  fetch_entry_t      head_entry;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     q_unfilled;
  logic              req_fire;
  logic              rsp_keep;
  logic              pop;

  // Request credit uses the registered count, so a full queue popping this cycle still waits
  always_comb begin
    imem_req_valid = reset_n && (q_count < CW'(QDEPTH)) && !redirect_valid;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  // Response routing, pop qualification and the head-driven outputs toward IF/ID
  always_comb begin
    rsp_keep        = reset_n && imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    fetch_valid     = (q_count != '0) && head_entry.filled;
    pop             = fetch_valid && !stall_i && !redirect_valid;
    Instruction_out = fetch_valid ? head_entry.instr : NOP;
    PC_plus_4_out   = fetch_valid ? head_entry.pc + 32'd4 : 32'd0;
  end

  // Everything still owed by memory becomes a discard once the queue is flushed
  always_comb begin
    outstanding         = drop_cnt + DROP_W'(q_unfilled);
    drop_after_redirect = (imem_rsp_valid && (outstanding != '0)) ? outstanding - 1'b1
                                                                  : outstanding;
  end

  // Next request address: redirect wins, otherwise advance on an accepted request
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
    end else if (req_fire) begin
      pc <= pc + 32'd4;
    end
  end

  // Count down wrong-path responses so none of them ever reaches the queue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= drop_after_redirect;
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .alloc      (req_fire),
    .alloc_pc   (pc),
    .fill       (rsp_keep),
    .fill_data  (imem_rsp_data),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (q_count),
    .unfilled   (q_unfilled)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a program-order reference
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        fetch_valid;
  logic [31:0] PC_plus_4_out;
  logic [31:0] Instruction_out;

  if_fetch_unit #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH),
    .NOP      (NOP)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall_i         (stall_i),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .fetch_valid     (fetch_valid),
    .PC_plus_4_out   (PC_plus_4_out),
    .Instruction_out (Instruction_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // stimulus knobs, applied by the driver just after each rising edge
  int          k_ready = 100;
  int          k_rsp   = 100;
  bit          k_stall = 1'b0;
  bit          k_redir = 1'b0;
  bit          k_rstn  = 1'b0;
  logic [31:0] k_rpc   = 32'd0;

  // memory model: every accepted address answered in order, at least one cycle later
  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } mreq_t;
  mreq_t       mem_pend[$];
  int          cyc = 0;
  logic [31:0] key = 32'h1234_5678;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ key;
  endfunction

  always @(posedge clk) begin
    cyc++;
    #1;
    reset_n        = k_rstn;
    stall_i        = k_stall;
    redirect_valid = k_redir;
    redirect_pc    = k_rpc;
    imem_req_ready = (int'($urandom_range(99)) < k_ready);
    if (mem_pend.size() > 0 && mem_pend[0].cyc < cyc && int'($urandom_range(99)) < k_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_pend[0].addr);
      void'(mem_pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // reference: the program-order instruction stream starting at the latest fetch target
  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] gen_addr     = 32'd0;
  logic [31:0] exp_req_addr = 32'd0;
  int          mcount       = 0;

  function automatic void refill();
    while (exp_q.size() < 16) begin
      exp_t e;
      e.pc4   = gen_addr + 32'd4;
      e.instr = mem_word(gen_addr);
      exp_q.push_back(e);
      gen_addr += 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] a);
    exp_q.delete();
    gen_addr     = a & 32'hFFFF_FFFC;
    exp_req_addr = gen_addr;
    mcount       = 0;
    refill();
  endfunction

  // monitor: compares every presented output against the scoreboard head
  always @(negedge clk) begin
    if (!reset_n) begin
      check("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
      mem_pend.delete();
      restart(RESET_PC);
    end else begin
      if (fetch_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(fetch_valid), 32'd0);
        end else begin
          check("pc_plus_4", PC_plus_4_out, exp_q[0].pc4);
          check("instruction", Instruction_out, exp_q[0].instr);
        end
      end else begin
        check("idle_instr", Instruction_out, NOP);
        check("idle_pc4", PC_plus_4_out, 32'd0);
      end
      check("req_valid", 32'(imem_req_valid), 32'((mcount < QDEPTH) && !redirect_valid));
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_addr);
      if (redirect_valid) begin
        restart(redirect_pc);
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          mem_pend.push_back('{addr: imem_req_addr, cyc: cyc});
          exp_req_addr += 32'd4;
          mcount++;
        end
        if (fetch_valid && !stall_i) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          mcount--;
          refill();
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    int          n;
    logic [31:0] held;
    key = $urandom;

    // reset, then a 1-cycle always-ready memory with no stall
    k_rstn = 1'b0;
    tick(3);
    check("reset_fetch_valid", 32'(fetch_valid), 32'd0);
    check("reset_instr", Instruction_out, NOP);
    check("reset_pc4", PC_plus_4_out, 32'd0);
    k_rstn = 1'b1;
    tick();
    check("c0_valid", 32'(fetch_valid), 32'd0);
    check("c0_addr", imem_req_addr, RESET_PC);
    tick();
    check("c1_valid", 32'(fetch_valid), 32'd0);
    check("c1_addr", imem_req_addr, RESET_PC + 32'd4);
    tick();
    check("c2_valid", 32'(fetch_valid), 32'd1);
    check("c2_pc4", PC_plus_4_out, 32'd4);
    tick();
    check("c3_pc4", PC_plus_4_out, 32'd8);
    tick();
    check("c4_pc4", PC_plus_4_out, 32'd12);

    // stall until the queue fills, then drain without bubbles
    k_stall = 1'b1;
    tick(5);
    check("full_req_valid", 32'(imem_req_valid), 32'd0);
    check("full_fetch_valid", 32'(fetch_valid), 32'd1);
    k_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain_no_gap", 32'(fetch_valid), 32'd1);
    end

    // redirect to 0x100 with two responses in flight
    k_ready = 0;
    tick(6);
    k_ready = 100;
    k_rsp   = 0;
    tick(2);
    k_redir = 1'b1;
    k_rpc   = 32'h0000_0100;
    k_rsp   = 100;
    tick();
    check("redir_req_gated", 32'(imem_req_valid), 32'd0);
    k_redir = 1'b0;
    tick();
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h0000_0100);
    n = 1;
    while (!fetch_valid && n < 40) begin
      tick();
      n++;
    end
    check("redir_valid_seen", 32'(fetch_valid), 32'd1);
    check("redir_latency", 32'(n >= 3), 32'd1);
    check("redir_first_pc4", PC_plus_4_out, 32'h0000_0104);

    // memory not ready for three cycles: address held
    tick(4);
    k_ready = 0;
    tick();
    held = exp_req_addr;
    check("hold_req_valid", 32'(imem_req_valid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_addr", imem_req_addr, held);
    end
    k_ready = 100;
    tick();
    check("hold_release_addr", imem_req_addr, held);

    // redirect and stall together while a response arrives
    tick(4);
    k_stall = 1'b1;
    k_redir = 1'b1;
    k_rpc   = 32'h0000_0203;
    tick();
    check("rs_req_gated", 32'(imem_req_valid), 32'd0);
    k_stall = 1'b0;
    k_redir = 1'b0;
    tick();
    check("rs_queue_empty", 32'(fetch_valid), 32'd0);
    check("rs_addr_aligned", imem_req_addr, 32'h0000_0200);
    tick(4);

    // reset mid-stream with responses in flight
    tick(3);
    k_rstn = 1'b0;
    tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    k_rstn = 1'b1;
    tick();
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_instr", Instruction_out, NOP);
    check("rst_pc4", PC_plus_4_out, 32'd0);
    check("rst_restart_addr", imem_req_addr, RESET_PC);
    tick(6);

    // randomized traffic, including targets that wrap the address space
    k_ready = 70;
    k_rsp   = 70;
    for (int i = 0; i < 2500; i++) begin
      k_stall = (int'($urandom_range(99)) < 25);
      if (int'($urandom_range(99)) < 4) begin
        k_redir = 1'b1;
        k_rpc   = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
      end else begin
        k_redir = 1'b0;
      end
      tick();
    end
    k_redir = 1'b0;
    k_stall = 1'b0;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the 5-stage pipeline, sitting directly upstream of the IF/ID pipeline register. Owns the program counter and issues in-order word requests to instruction memory over a valid/ready request channel with an in-order response channel. Buffers returned instructions in a small queue and presents one instruction per cycle, with its PC+4, to IF/ID. Supports stall from the hazard unit and redirect (taken branch/jump), discarding stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `QDEPTH`, 4, fetch-queue entries (power of 2, ≥2)
- `NOP`, 32'h0000_0013, instruction driven when no valid fetch
- `clk` in 1, single clock; all state updates on posedge
- `reset_n` in 1, synchronous, active-low reset
- `stall_i` in 1, hazard unit holds IF/ID; no pop
- `redirect_valid` in 1, taken branch/jump this cycle
- `redirect_pc` in 32, new fetch address (word-aligned)
- `imem_req_valid` out 1, request pending
- `imem_req_ready` in 1, memory accepts request
- `imem_req_addr` out 32, request address
- `imem_rsp_valid` in 1, response word present (in order, ≥1 cycle after acceptance)
- `imem_rsp_data` in 32, instruction word
- `fetch_valid` out 1, queue head holds a filled instruction
- `PC_plus_4_out` out 32, head PC + 4; 0 when `fetch_valid`=0
- `Instruction_out` out 32, head instruction; `NOP` when `fetch_valid`=0

## Operation
- State: `pc` (next request address), circular queue of {pc, instr, filled}, head/tail pointers, `count` (allocated entries), `drop_cnt` (responses to discard).
- Reset (`reset_n`=0 at edge): `pc`=RESET_PC, queue empty, `drop_cnt`=0. Outputs then: `imem_req_valid`=0 during reset cycle; `fetch_valid`=0, `Instruction_out`=NOP, `PC_plus_4_out`=0.
- Request: `imem_req_valid` = (`count`<QDEPTH) && !`redirect_valid`; `imem_req_addr`=`pc`. On handshake: allocate tail entry {pc, filled=0}, `pc`+=4 (mod 2^32, wraps).
- Response: if `drop_cnt`>0, discard, `drop_cnt`−1; else fill oldest unfilled entry.
- Pop: when `fetch_valid` && !`stall_i` && !`redirect_valid`, head advances, `count`−1.
- Same-cycle allocate+pop: `count` unchanged; queue full and pop same cycle does not permit request (credit uses registered `count`).
- Redirect (priority over stall, pop, request): `pc`=`redirect_pc`; queue emptied; `drop_cnt` = responses still outstanding after this cycle (allocated-unfilled entries plus prior `drop_cnt`, minus one if a response arrives this cycle). Response arriving in redirect cycle is discarded.
- IF/ID flush on redirect is the hazard unit's responsibility; this block only guarantees no wrong-path word after the redirect edge.
- Misaligned `redirect_pc`: low 2 bits forced to 0.

## Timing
- Request accepted cycle N, response N+1 → `fetch_valid`=1 in N+2 (registered queue, combinational outputs from head).
- Steady-state with 1-cycle memory and QDEPTH=4: one instruction per cycle.
- First request: cycle after `reset_n` goes high, address RESET_PC.
- Redirect at cycle R: first request to `redirect_pc` at R+1; its instruction valid no earlier than R+3.
- `stall_i` holds head and outputs stable; requests continue until queue full.

## Structure
- Package `fetch_pkg`: `NOP` encoding, `RESET_PC` default, queue entry struct {pc, instr, filled}.
- Sub-module `fetch_queue`: circular buffer with allocate, fill-oldest-unfilled, pop, flush; exports head entry, `count`, unfilled count.
- Top handles PC, request gating, drop counter, redirect priority.

## Test plan
- Reset then 1-cycle memory, always ready, no stall → addresses 0,4,8,… one per cycle; `fetch_valid` first at cycle 2 post-reset, `PC_plus_4_out`=4, then 8, 12 consecutively.
- `stall_i` high 5 cycles with queue filling → exactly 4 requests outstanding/buffered, `imem_req_valid`=0 when full, outputs frozen; release → in-order drain without gaps.
- Redirect to 0x100 with 2 responses in flight → both discarded, next valid instruction has `PC_plus_4_out`=0x104, no stale word ever `fetch_valid`.
- `imem_req_ready` low 3 cycles → `imem_req_addr` held, `pc` unchanged, no allocation.
- `redirect_valid` and `stall_i` same cycle with response arriving → redirect wins, response dropped, queue empty next cycle.
- `reset_n` low mid-stream with responses in flight → all outputs reset values next cycle, fetch restarts at RESET_PC.
